// File: rtl/alu_slice_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_slice_sequencer
// Purpose  : Runs W = M*K bit ADD/SUB/CMP/ADC operations on an external M-bit
//            ALU slice, one slice per cycle with the LSB slice first. The carry
//            is chained between slices through a register. The Z/N/V/C flags
//            are accumulated over the whole word, and the committed result and
//            flags are held until the next operation completes.
// Ports    : clk, rst (sync, active-low)
//            start/op/a/b       - operation request from decode
//            busy/done          - status (done is a one-cycle commit pulse)
//            result/Z/N/V/C     - committed result and flags
//            alu_a/alu_b/alu_cin - slice operands driven to the ALU
//            alu_sum/alu_cout   - slice response from the ALU
// Revision : 1.0 - initial release
// ============================================================================
module alu_slice_sequencer #(
    parameter int M = 4,
    parameter int K = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [M*K-1:0]   a,
    input  logic [M*K-1:0]   b,
    output logic             busy,
    output logic             done,
    output logic [M*K-1:0]   result,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             C,
    output logic [M-1:0]     alu_a,
    output logic [M-1:0]     alu_b,
    output logic             alu_cin,
    input  logic [M-1:0]     alu_sum,
    input  logic             alu_cout
);

    localparam int W  = M * K;
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_CMP = 2'b10;
    localparam logic [1:0] c_OP_ADC = 2'b11;

    logic [1:0]    r_state;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;        // holds b already inverted for SUB/CMP
    logic [1:0]    r_op;
    logic [W-1:0]  r_shadow;
    logic          r_zacc;
    logic          r_carry;    // carry-out of the previous slice

    logic          w_run;
    logic          w_last;
    logic          w_zacc_nxt;
    logic          w_ovf;
    logic [W-1:0]  w_shadow_nxt;
    logic [M-1:0]  w_a_sl [K];
    logic [M-1:0]  w_b_sl [K];

    assign w_run  = (r_state == c_RUN);
    assign w_last = (r_idx == IW'(K - 1));
    assign busy   = (r_state != c_IDLE);
    assign done   = (r_state == c_DONE);

    // Slice views of the operand registers, and the shadow register with the
    // current slice replaced by the ALU sum (what the shadow holds next cycle).
    for (genvar g = 0; g < K; g++) begin : g_slice
        assign w_a_sl[g] = r_a[g*M +: M];
        assign w_b_sl[g] = r_b[g*M +: M];
        assign w_shadow_nxt[g*M +: M] = (r_idx == IW'(g)) ? alu_sum : r_shadow[g*M +: M];
    end

    assign w_zacc_nxt = r_zacc & (alu_sum == '0);
    // Only meaningful on the last slice: the MSBs of the operands as fed to the
    // ALU agree but the sum's MSB differs from them.
    assign w_ovf      = (r_a[W-1] == r_b[W-1]) & (alu_sum[M-1] != r_a[W-1]);

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        if (w_run) begin
            alu_a = w_a_sl[r_idx];
            alu_b = w_b_sl[r_idx];
            if (r_idx == '0) begin
                case (r_op)
                    c_OP_ADD: alu_cin = 1'b0;
                    c_OP_ADC: alu_cin = C;     // committed carry from the previous op
                    default:  alu_cin = 1'b1;  // +1 completes the two's complement of b
                endcase
            end else begin
                alu_cin = r_carry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= c_IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= c_OP_ADD;
            r_shadow <= '0;
            r_zacc   <= 1'b0;
            r_carry  <= 1'b0;
            result   <= '0;
            Z        <= 1'b0;
            N        <= 1'b0;
            V        <= 1'b0;
            C        <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= ((op == c_OP_SUB) || (op == c_OP_CMP)) ? ~b : b;
                        r_op    <= op;
                        r_zacc  <= 1'b1;
                        r_idx   <= '0;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_shadow <= w_shadow_nxt;
                    r_zacc   <= w_zacc_nxt;
                    r_carry  <= alu_cout;
                    if (w_last) begin
                        // Commit on entry to DONE, using this cycle's final slice
                        // directly so the flags see the complete word.
                        if (r_op != c_OP_CMP) begin
                            result <= w_shadow_nxt;
                        end
                        Z       <= w_zacc_nxt;
                        N       <= w_shadow_nxt[W-1];
                        C       <= alu_cout;
                        V       <= w_ovf;
                        r_idx   <= '0;
                        r_state <= c_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_slice_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_slice_sequencer
// Purpose  : Self-checking bench for alu_slice_sequencer with an M-bit adder
//            slice model, directed cases and randomized operations scored
//            against a word-level arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_slice_sequencer;

    localparam int M = 4;
    localparam int K = 4;
    localparam int W = M * K;

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_CMP = 2'b10;
    localparam logic [1:0] c_OP_ADC = 2'b11;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         n;
        logic         v;
        logic         c;
    } exp_t;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, Z, N, V, C, alu_cin, alu_cout;
    logic [W-1:0] result;
    logic [M-1:0] alu_a, alu_b, alu_sum;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    exp_t hold     = '0;
    logic [W-1:0] m_result = '0;
    logic         m_c      = 1'b0;

    alu_slice_sequencer #(.M(M), .K(K)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .Z(Z), .N(N), .V(V), .C(C),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_sum(alu_sum), .alu_cout(alu_cout)
    );

    // The shared ALU slice itself: a plain M-bit adder.
    assign {alu_cout, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b} + {{M{1'b0}}, alu_cin};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word-level reference: signed/unsigned arithmetic on the whole operands.
    task automatic model_push(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint ux, uy, sx, sy, us, ss;
        exp_t   e;
        logic [W-1:0] r;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            c_OP_ADD: begin us = ux + uy; ss = sx + sy; end
            c_OP_ADC: begin us = ux + uy + longint'(m_c); ss = sx + sy + longint'(m_c); end
            default:  begin us = ux - uy; ss = sx - sy; end
        endcase
        r     = us[W-1:0];
        e.c   = (o == c_OP_SUB || o == c_OP_CMP) ? (ux >= uy) : (us >= 65536);
        e.v   = (ss > 32767) || (ss < -32768);
        e.z   = (r == '0);
        e.n   = r[W-1];
        e.res = (o == c_OP_CMP) ? m_result : r;
        m_result = e.res;
        m_c      = e.c;
        q.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: busy stuck at %0b, required 0", busy);
        end
    endtask

    // Returns 1ns after the accepting edge, i.e. inside cycle t+1.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        wait_idle();
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) model_push(o, x, y);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Monitor: scoreboard pop on done, plus output stability and idle ALU ports.
    always @(negedge clk) begin
        if (rst) begin
            if (done) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: done=1 with no operation outstanding, required 0");
                end else begin
                    hold = q.pop_front();
                    chk("sb_result", 32'(result), 32'(hold.res));
                    chk("sb_flags_ZNVC", 32'({Z, N, V, C}), 32'({hold.z, hold.n, hold.v, hold.c}));
                end
            end else if (busy) begin
                chk("hold_during_run", 32'({result, Z, N, V, C}), 32'(hold));
            end else begin
                chk("idle_alu_ports", 32'({alu_a, alu_b, alu_cin}), 32'd0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3:0] cin_exp;

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({Z, N, V, C}), 32'd0);
        rst = 1'b1;

        // ADD with cycle-accurate timing
        cin_exp = 4'b0110;  // slice order 0..3: 0,1,1,0
        issue(c_OP_ADD, 16'h00FF, 16'h0001, 1'b1);
        for (int k = 1; k <= K + 2; k++) begin
            @(negedge clk);
            chk($sformatf("add_busy_t%0d", k), 32'(busy), 32'(k <= K + 1));
            chk($sformatf("add_done_t%0d", k), 32'(done), 32'(k == K + 1));
            if (k <= K) chk($sformatf("add_cin_slice%0d", k - 1), 32'(alu_cin), 32'(cin_exp[k-1]));
        end
        chk("add_result", 32'(result), 32'h0100);
        chk("add_flags", 32'({Z, N, V, C}), 32'b0000);
        @(posedge clk); #1;

        // SUB with signed overflow
        issue(c_OP_SUB, 16'h8000, 16'h0001, 1'b1);
        @(negedge clk);
        chk("sub_alu_b_slice0", 32'(alu_b), 32'hE);
        chk("sub_alu_cin_slice0", 32'(alu_cin), 32'd1);
        @(posedge clk); #1;
        wait_idle();
        chk("sub_result", 32'(result), 32'h7FFF);
        chk("sub_flags", 32'({Z, N, V, C}), 32'b0011);

        // ADD wrap then ADC consumes the carry
        issue(c_OP_ADD, 16'hFFFF, 16'h0001, 1'b1);
        wait_idle();
        chk("wrap_result", 32'(result), 32'h0000);
        chk("wrap_flags", 32'({Z, N, V, C}), 32'b1001);
        issue(c_OP_ADC, 16'h0000, 16'h0000, 1'b1);
        wait_idle();
        chk("adc_result", 32'(result), 32'h0001);
        chk("adc_flags", 32'({Z, N, V, C}), 32'b0000);

        // CMP keeps result
        issue(c_OP_CMP, 16'h1234, 16'h1234, 1'b1);
        wait_idle();
        chk("cmp_result", 32'(result), 32'h0001);
        chk("cmp_flags", 32'({Z, N, V, C}), 32'b1001);

        // start while busy is ignored
        issue(c_OP_ADD, 16'h0F0F, 16'h0101, 1'b1);
        start = 1'b1; op = c_OP_ADD; a = 16'h1111; b = 16'h2222;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        chk("busy_ignore_result", 32'(result), 32'h1010);
        @(negedge clk);
        chk("busy_ignore_no_reaccept", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Reset while slice 2 is on the ALU
        issue(c_OP_ADD, 16'h4321, 16'h1111, 1'b0);
        @(posedge clk); #1;               // cycle t+2
        @(posedge clk); #1;               // cycle t+3: slice 2
        rst = 1'b0;
        @(posedge clk); #1;
        rst      = 1'b1;
        hold     = '0;
        m_result = '0;
        m_c      = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_flags", 32'({Z, N, V, C}), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        issue(c_OP_ADD, 16'h0001, 16'h0002, 1'b1);
        wait_idle();
        chk("post_reset_result", 32'(result), 32'h0003);

        // Randomized operations
        for (int n = 0; n < 60; n++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ra;
            if ($urandom_range(0, 7) == 0) ra = 16'h8000;
            issue(ro, ra, rb, 1'b1);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
